// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Clocked by the PLL output clock. It synchronises the PLL lock flag and waits
// for lock to stay stable for SETTLE_CYCLES cycles. It then holds the core in
// reset for RESET_CYCLES more cycles before releasing it. While running, it
// produces a one-cycle clock-enable strobe every CE_DIV cycles. Any loss of lock
// puts the core back in reset at once and restarts the sequence.
//
// Optional build macro LOCK_LOSS_COUNT_EN:
//   defined   - lock_loss_cnt counts RUN -> WAIT_LOCK transitions. It saturates
//               at 255 and is cleared only by rst_n.
//   undefined - lock_loss_cnt is tied to zero. The port is still present.
//
// Reset is synchronous and active-low. It is sampled on the rising clock edge.
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 1024,
   parameter int RESET_CYCLES  = 16,
   parameter int CE_DIV        = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   output logic       core_rst_n,
   output logic       ce_div,
   output logic       pll_locked,
   output logic [7:0] lock_loss_cnt
);

   // The sequence counter is wide enough for the longer of the two phases,
   // plus one bit of headroom.
   localparam int MAX_CYC = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int DIV_W   = $clog2(CE_DIV) + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_ZERO    = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CE_DIV - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      HOLD_RST  = 2'd2,
      RUN       = 2'd3
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;

   state_e                 state_q;
   state_e                 state_d;
   logic [CNT_W-1:0]       seq_cnt_q;
   logic [CNT_W-1:0]       seq_cnt_d;
   logic [DIV_W-1:0]       div_cnt_q;
   logic [DIV_W-1:0]       div_cnt_d;
   logic                   ce_div_d;
   logic                   core_rst_n_q;
   logic                   ce_div_q;

   // Lock synchroniser: pll_lock enters at bit 0 and moves toward the MSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      end
   end

   assign lock_s = sync_q[SYNC_STAGES-1];

   // Sequencer next state. Loss of lock takes priority over any terminal count.
   always_comb begin
      state_d   = state_q;
      seq_cnt_d = seq_cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            seq_cnt_d = CNT_ZERO;
            if (lock_s) begin
               state_d = SETTLE;
            end else begin
               state_d = WAIT_LOCK;
            end
         end
         SETTLE: begin
            if (!lock_s) begin
               state_d   = WAIT_LOCK;
               seq_cnt_d = CNT_ZERO;
            end else if (seq_cnt_q == SETTLE_LAST) begin
               state_d   = HOLD_RST;
               seq_cnt_d = CNT_ZERO;
            end else begin
               seq_cnt_d = seq_cnt_q + CNT_ONE;
            end
         end
         HOLD_RST: begin
            if (!lock_s) begin
               state_d   = WAIT_LOCK;
               seq_cnt_d = CNT_ZERO;
            end else if (seq_cnt_q == RESET_LAST) begin
               state_d   = RUN;
               seq_cnt_d = CNT_ZERO;
            end else begin
               seq_cnt_d = seq_cnt_q + CNT_ONE;
            end
         end
         RUN: begin
            seq_cnt_d = CNT_ZERO;
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d   = WAIT_LOCK;
            seq_cnt_d = CNT_ZERO;
         end
      endcase
   end

   // Divider next state. It counts only between two consecutive RUN cycles, so
   // the first RUN cycle always starts at zero.
   always_comb begin
      if ((state_q == RUN) && (state_d == RUN)) begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = DIV_ZERO;
         end else begin
            div_cnt_d = div_cnt_q + DIV_ONE;
         end
      end else begin
         div_cnt_d = DIV_ZERO;
      end
      ce_div_d = (state_d == RUN) && (div_cnt_d == DIV_LAST);
   end

   // Sequencer state, counters and registered outputs. core_rst_n is loaded
   // from the next state, so it is high exactly while the FSM is in RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= WAIT_LOCK;
         seq_cnt_q    <= CNT_ZERO;
         div_cnt_q    <= DIV_ZERO;
         core_rst_n_q <= 1'b0;
         ce_div_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         seq_cnt_q    <= seq_cnt_d;
         div_cnt_q    <= div_cnt_d;
         core_rst_n_q <= (state_d == RUN);
         ce_div_q     <= ce_div_d;
      end
   end

   assign core_rst_n = core_rst_n_q;
   assign ce_div     = ce_div_q;
   assign pll_locked = lock_s;

`ifdef LOCK_LOSS_COUNT_EN
   logic       lock_lost_s;
   logic [7:0] loss_cnt_q;

   // Only a drop out of RUN counts. Drops during settle or hold do not count.
   assign lock_lost_s = (state_q == RUN) && !lock_s;

   // Saturating lock-loss counter. It is cleared only by rst_n.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         loss_cnt_q <= 8'd0;
      end else if (lock_lost_s && (loss_cnt_q != 8'd255)) begin
         loss_cnt_q <= loss_cnt_q + 8'd1;
      end else begin
         loss_cnt_q <= loss_cnt_q;
      end
   end

   assign lock_loss_cnt = loss_cnt_q;
`else
   assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for pll_reset_sequencer.
// dut0: SYNC_STAGES=2, SETTLE_CYCLES=8, RESET_CYCLES=4, CE_DIV=4
// dut1: same, but with CE_DIV=1
// Both instances share clock, reset and pll_lock.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

`ifdef LOCK_LOSS_COUNT_EN
   localparam int CNT_EN = 1;
`else
   localparam int CNT_EN = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic       pll_lock;
   logic       core_rst_n0, ce_div0, pll_locked0;
   logic [7:0] loss_cnt0;
   logic       core_rst_n1, ce_div1, pll_locked1;
   logic [7:0] loss_cnt1;

   int errors = 0;
   int checks = 0;

   pll_reset_sequencer #(
      .SYNC_STAGES(2), .SETTLE_CYCLES(8), .RESET_CYCLES(4), .CE_DIV(4)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
      .core_rst_n(core_rst_n0), .ce_div(ce_div0),
      .pll_locked(pll_locked0), .lock_loss_cnt(loss_cnt0)
   );

   pll_reset_sequencer #(
      .SYNC_STAGES(2), .SETTLE_CYCLES(8), .RESET_CYCLES(4), .CE_DIV(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
      .core_rst_n(core_rst_n1), .ce_div(ce_div1),
      .pll_locked(pll_locked1), .lock_loss_cnt(loss_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count edges until dut0 releases core reset (no comparison here).
   // Returns limit+1 if the release never happens.
   task automatic measure_release(input int limit, output int n);
      bit done;
      done = 1'b0;
      n = limit + 1;
      for (int i = 1; i <= limit; i++) begin
         if (!done) begin
            step();
            if (core_rst_n0 === 1'b1) begin
               n = i;
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pll_lock = 1'b1;
      step();
      step();
      checks++; if (core_rst_n0 !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n: got %b expected 0", core_rst_n0); end
      checks++; if (ce_div0 !== 1'b0) begin errors++; $display("FAIL reset_ce_div: got %b expected 0", ce_div0); end
      checks++; if (pll_locked0 !== 1'b0) begin errors++; $display("FAIL reset_pll_locked: got %b expected 0", pll_locked0); end
      checks++; if (loss_cnt0 !== 8'd0) begin errors++; $display("FAIL reset_loss_cnt: got %0d expected 0", loss_cnt0); end
      checks++; if (ce_div1 !== 1'b0) begin errors++; $display("FAIL reset_ce_div1: got %b expected 0", ce_div1); end
   endtask

   task automatic test_nominal();
      int n;
      rst_n = 1'b1;
      pll_lock = 1'b1;
      measure_release(40, n);
      checks++; if (n !== 15) begin errors++; $display("FAIL nominal_release_edge: got %0d expected 15", n); end
      checks++; if (pll_locked0 !== 1'b1) begin errors++; $display("FAIL nominal_pll_locked: got %b expected 1", pll_locked0); end
      checks++; if (ce_div0 !== 1'b0) begin errors++; $display("FAIL nominal_ce_first_cycle: got %b expected 0", ce_div0); end
      checks++; if (ce_div1 !== 1'b1) begin errors++; $display("FAIL nominal_ce1_first_cycle: got %b expected 1", ce_div1); end
      for (int k = 1; k <= 12; k++) begin
         step();
         checks++;
         if (ce_div0 !== ((k % 4) == 3)) begin
            errors++;
            $display("FAIL nominal_ce_div run_cycle=%0d: got %b expected %b", k + 1, ce_div0, ((k % 4) == 3));
         end
         checks++; if (core_rst_n0 !== 1'b1) begin errors++; $display("FAIL nominal_core_held run_cycle=%0d: got %b expected 1", k + 1, core_rst_n0); end
         checks++; if (ce_div1 !== 1'b1) begin errors++; $display("FAIL nominal_ce1 run_cycle=%0d: got %b expected 1", k + 1, ce_div1); end
      end
   endtask

   task automatic test_lock_loss();
      int n;
      logic [7:0] exp_cnt;
      pll_lock = 1'b0;
      step();
      checks++; if (core_rst_n0 !== 1'b1) begin errors++; $display("FAIL loss_edge1_core: got %b expected 1", core_rst_n0); end
      step();
      checks++; if (core_rst_n0 !== 1'b1) begin errors++; $display("FAIL loss_edge2_core: got %b expected 1", core_rst_n0); end
      checks++; if (ce_div1 !== 1'b1) begin errors++; $display("FAIL loss_edge2_ce1: got %b expected 1", ce_div1); end
      step();
      checks++; if (core_rst_n0 !== 1'b0) begin errors++; $display("FAIL loss_core_rst_n: got %b expected 0", core_rst_n0); end
      checks++; if (ce_div0 !== 1'b0) begin errors++; $display("FAIL loss_ce_div: got %b expected 0", ce_div0); end
      checks++; if (ce_div1 !== 1'b0) begin errors++; $display("FAIL loss_ce_div1: got %b expected 0", ce_div1); end
      checks++; if (core_rst_n1 !== 1'b0) begin errors++; $display("FAIL loss_core_rst_n1: got %b expected 0", core_rst_n1); end
      checks++; if (pll_locked0 !== 1'b0) begin errors++; $display("FAIL loss_pll_locked: got %b expected 0", pll_locked0); end
      pll_lock = 1'b1;
      measure_release(40, n);
      checks++; if (n !== 15) begin errors++; $display("FAIL loss_relock_release_edge: got %0d expected 15", n); end
      exp_cnt = (CNT_EN != 0) ? 8'd1 : 8'd0;
      checks++; if (loss_cnt0 !== exp_cnt) begin errors++; $display("FAIL loss_count: got %0d expected %0d", loss_cnt0, exp_cnt); end
   endtask

   task automatic test_reset_mid_hold();
      int n;
      logic [7:0] exp_cnt;
      pll_lock = 1'b0;
      step();
      step();
      step();
      exp_cnt = (CNT_EN != 0) ? 8'd2 : 8'd0;
      checks++; if (loss_cnt0 !== exp_cnt) begin errors++; $display("FAIL hold_pre_loss_count: got %0d expected %0d", loss_cnt0, exp_cnt); end
      pll_lock = 1'b1;
      for (int i = 0; i < 12; i++) step();
      checks++; if (core_rst_n0 !== 1'b0) begin errors++; $display("FAIL hold_core_in_hold: got %b expected 0", core_rst_n0); end
      rst_n = 1'b0;
      step();
      checks++; if (core_rst_n0 !== 1'b0) begin errors++; $display("FAIL hold_rst_core: got %b expected 0", core_rst_n0); end
      checks++; if (ce_div0 !== 1'b0) begin errors++; $display("FAIL hold_rst_ce: got %b expected 0", ce_div0); end
      checks++; if (pll_locked0 !== 1'b0) begin errors++; $display("FAIL hold_rst_pll_locked: got %b expected 0", pll_locked0); end
      checks++; if (loss_cnt0 !== 8'd0) begin errors++; $display("FAIL hold_rst_loss_cnt: got %0d expected 0", loss_cnt0); end
      rst_n = 1'b1;
      measure_release(40, n);
      checks++; if (n !== 15) begin errors++; $display("FAIL hold_restart_release_edge: got %0d expected 15", n); end
   endtask

   task automatic test_glitch_settle();
      int n;
      rst_n = 1'b0;
      pll_lock = 1'b1;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step();
      pll_lock = 1'b0;
      step();
      checks++; if (pll_locked0 !== 1'b1) begin errors++; $display("FAIL glitch_pre_locked: got %b expected 1", pll_locked0); end
      pll_lock = 1'b1;
      step();
      checks++; if (pll_locked0 !== 1'b0) begin errors++; $display("FAIL glitch_seen: got %b expected 0", pll_locked0); end
      measure_release(40, n);
      checks++; if (n !== 14) begin errors++; $display("FAIL glitch_release_edge: got %0d expected 14", n); end
      checks++; if (loss_cnt0 !== 8'd0) begin errors++; $display("FAIL glitch_not_counted: got %0d expected 0", loss_cnt0); end
   endtask

   task automatic test_saturation();
      int n;
      int bad;
      logic [7:0] exp_cnt;
      bad = 0;
      rst_n = 1'b0;
      pll_lock = 1'b0;
      step();
      rst_n = 1'b1;
      exp_cnt = (CNT_EN != 0) ? 8'd255 : 8'd0;
      for (int i = 0; i < 260; i++) begin
         pll_lock = 1'b1;
         measure_release(40, n);
         if (n !== 15) bad++;
         pll_lock = 1'b0;
         step();
         step();
         step();
         if (i == 254) begin
            checks++; if (loss_cnt0 !== exp_cnt) begin errors++; $display("FAIL sat_count_255: got %0d expected %0d", loss_cnt0, exp_cnt); end
         end
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL sat_release_latency: got %0d bad releases expected 0", bad); end
      checks++; if (loss_cnt0 !== exp_cnt) begin errors++; $display("FAIL sat_count_260: got %0d expected %0d", loss_cnt0, exp_cnt); end
      checks++; if (loss_cnt1 !== exp_cnt) begin errors++; $display("FAIL sat_count_dut1: got %0d expected %0d", loss_cnt1, exp_cnt); end
   endtask

   task automatic test_ce_div1();
      rst_n = 1'b0;
      pll_lock = 1'b1;
      step();
      rst_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         step();
         checks++;
         if (ce_div1 !== (e >= 15)) begin
            errors++;
            $display("FAIL ce1_edge%0d: got %b expected %b", e, ce_div1, (e >= 15));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      pll_lock = 1'b0;
      test_reset();
      test_nominal();
      test_lock_loss();
      test_reset_mid_hold();
      test_glitch_settle();
      test_saturation();
      test_ce_div1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
